bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single external memory bus between instruction fetch and the memory pipeline stage (loads/stores).
- One transaction outstanding at a time; data has priority over fetch.
- Produces byte strobes and replicated store data, and aligns and sign-/zero-extends load data for the memory stage.
- Its ready pulses are what the hazard unit uses to release fetch and memory-stage stalls.

Parameters:
FAIR_LIMIT, 4, consecutive data grants allowed while fetch waits (only with ARBITER_FAIRNESS_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_req  in  1  fetch request; level, held until fetch_ready
fetch_address  in  32  fetch address (word aligned)
fetch_data  out  32  fetched word, valid with fetch_ready
fetch_ready  out  1  one-cycle completion pulse for fetch
mem_load  in  1  load request; level, held until mem_ready
mem_store  in  1  store request; level, held until mem_ready
mem_address  in  32  byte address (alignment checked upstream)
mem_store_data  in  32  store data, right-justified
mem_size  in  2  00 byte, 01 half, 10 word
mem_signed  in  1  sign-extend loaded byte/half
mem_load_data  out  32  aligned/extended load data, valid with mem_ready
mem_ready  out  1  one-cycle completion pulse for load/store
ext_valid  out  1  bus request; held until ext_ready
ext_write  out  1  1 = write
ext_address  out  32  word address ({addr[31:2],2'b00})
ext_wdata  out  32  lane-replicated write data
ext_strobe  out  4  byte enables
ext_rdata  in  32  read data, valid with ext_ready
ext_ready  in  1  bus completion, sampled while ext_valid=1

Behaviour:
- States: IDLE, DATA, FETCH, DONE. Reset (sync) -> IDLE; ext_valid, ext_write, ext_strobe, fetch_ready, mem_ready = 0; data outputs = 0.
- IDLE: if mem_load|mem_store -> DATA, else if fetch_req -> FETCH.
  - On grant, register ext_address, ext_write (=mem_store; fetch -> 0), ext_wdata and ext_strobe.
  - A request seen in cycle N gives ext_valid=1 from N+1.
- DATA/FETCH: ext_valid=1, all ext_* stable until ext_ready.
  - On ext_ready at cycle M: register the response and go to DONE.
  - At M+1, the granted requester's ready = 1 for exactly one cycle; its data output is updated, the other's data output holds.
- DONE: no grant even if requests are still high (the requester drops or advances on the ready edge). Next cycle -> IDLE.
  - Minimum 3 cycles per transaction; back-to-back throughput 1 per 3 cycles.
- Strobes:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
  - Loads drive the same strobe; fetch drives 1111.
- Write data: byte replicated x4, half replicated x2, word as-is.
- Load alignment: shift ext_rdata right by addr[1:0]*8; take 8/16/32 bits by size; extend per mem_signed. Fetch data passes unmodified.
- mem_size=11 never issued by the memory stage; treated as word, no error.
- mem_load and mem_store both high: treated as store (ext_write=1), returns mem_ready.
- Requests dropping mid-transaction: the transaction still completes; ready still pulses.
- Reset mid-transaction: IDLE next edge, ext_valid drops; the bus must tolerate an abandoned request.

Optional Feature:
ARBITER_FAIRNESS_EN
- Defined:
  - A counter increments per data grant issued while fetch_req=1.
  - When count==FAIR_LIMIT and fetch_req=1, the next IDLE grant goes to FETCH even if data is pending.
  - The counter clears on a fetch grant, on fetch_req=0, and on reset.
- Undefined: strict data priority; counter and parameter have no effect.

Decomposition:
- Package bus_pkg: state enum (IDLE, DATA, FETCH, DONE); size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10; strobe-generation function.
- Sub-module bus_load_align: combinational shift/extract/extend of read data from address[1:0], size and signed.

Test Plan:
- Fetch only: fetch_address=0x100, ext_rdata=0x00000013, ext_ready 2 cycles after ext_valid -> ext_address=0x100, strobe 1111, fetch_data=0x13, one-cycle fetch_ready.
- Simultaneous fetch_req and mem_load at 0x200 -> DATA granted first; fetch granted only after DONE.
- Signed byte load at 0x203, ext_rdata=0x80112233 -> strobe 1000, mem_load_data=0xFFFFFF80; unsigned gives 0x00000080.
- Half store 0xABCD at 0x302 -> ext_address=0x300, strobe 1100, ext_wdata=0xABCDABCD, ext_write=1.
- Reset asserted while ext_valid=1 and ext_ready=0 -> IDLE next cycle, ext_valid=0, no ready pulse.
- With ARBITER_FAIRNESS_EN, FAIR_LIMIT=4: loads held continuously plus fetch_req -> 4 data grants, then 1 fetch grant, then data resumes.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbiter: FSM states, access sizes,
// byte-strobe and store-lane generation.
package bus_pkg;

  typedef enum logic [1:0] {StIdle, StData, StFetch, StDone} bus_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Size 2'b11 is never issued upstream; it falls through to a full word.
  function automatic logic [3:0] strobe_for(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return 4'b0011 << {offset[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/bus_load_align.sv
// Shifts bus read data down to the addressed byte lane, keeps 8/16/32 bits
// by access size and sign- or zero-extends the result.
module bus_load_align
  import bus_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SIZE_BYTE: data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the single external bus between instruction fetch and the memory
// stage; one transaction at a time, data first. Define ARBITER_FAIRNESS_EN to
// force a fetch grant after FAIR_LIMIT consecutive data grants.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic [31:0] mem_load_data,
  output logic        mem_ready,
  output logic        ext_valid,
  output logic        ext_write,
  output logic [31:0] ext_address,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_strobe,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ready
);

  bus_state_e  state_q, state_d;
  logic        grant_data, grant_fetch, fetch_force;
  logic        is_fetch_q, write_q, signed_q;
  logic [31:0] addr_q, wdata_q, fetch_data_q, load_data_q, aligned;
  logic [3:0]  strobe_q;
  logic [1:0]  offset_q, size_q;
  logic        data_req;
  logic        unused_fetch_lsb;

  assign data_req         = mem_load | mem_store;
  assign unused_fetch_lsb = ^fetch_address[1:0];

`ifdef ARBITER_FAIRNESS_EN
  localparam int unsigned CntW = $clog2(FAIR_LIMIT + 1);
  logic [CntW-1:0] fair_cnt_q;

  assign fetch_force = fetch_req && (fair_cnt_q == CntW'(FAIR_LIMIT));

  always_ff @(posedge clk) begin
    if (reset || !fetch_req || grant_fetch) begin
      fair_cnt_q <= '0;
    end else if (grant_data && fair_cnt_q != CntW'(FAIR_LIMIT)) begin
      fair_cnt_q <= fair_cnt_q + 1'b1;
    end
  end
`else
  logic unused_fair;
  assign unused_fair = (FAIR_LIMIT == 0);
  assign fetch_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    case (state_q)
      StIdle: begin
        if (data_req && !fetch_force) begin
          grant_data = 1'b1;
          state_d    = StData;
        end else if (fetch_req) begin
          grant_fetch = 1'b1;
          state_d     = StFetch;
        end
      end
      StData, StFetch: begin
        if (ext_ready) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ext_valid   = (state_q == StData) || (state_q == StFetch);
    fetch_ready = (state_q == StDone) && is_fetch_q;
    mem_ready   = (state_q == StDone) && !is_fetch_q;
  end

  bus_load_align u_load_align (
    .rdata_i  (ext_rdata),
    .offset_i (offset_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (aligned)
  );

  // Transaction attributes are latched at grant so requesters may drop mid-flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      offset_q     <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      is_fetch_q   <= 1'b0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
    end else begin
      if (grant_data) begin
        addr_q     <= {mem_address[31:2], 2'b00};
        write_q    <= mem_store;
        wdata_q    <= wdata_for(mem_size, mem_store_data);
        strobe_q   <= strobe_for(mem_size, mem_address[1:0]);
        offset_q   <= mem_address[1:0];
        size_q     <= mem_size;
        signed_q   <= mem_signed;
        is_fetch_q <= 1'b0;
      end else if (grant_fetch) begin
        addr_q     <= {fetch_address[31:2], 2'b00};
        write_q    <= 1'b0;
        wdata_q    <= '0;
        strobe_q   <= 4'b1111;
        is_fetch_q <= 1'b1;
      end
      if (ext_valid && ext_ready) begin
        if (is_fetch_q) begin
          fetch_data_q <= ext_rdata;
        end else if (!write_q) begin
          load_data_q <= aligned;
        end
      end
    end
  end

  assign ext_address   = addr_q;
  assign ext_write     = write_q;
  assign ext_wdata     = wdata_q;
  assign ext_strobe    = strobe_q;
  assign fetch_data    = fetch_data_q;
  assign mem_load_data = load_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions checked against a byte-lane reference model.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_address = '0;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_store_data = '0;
  logic [1:0]  mem_size = 2'b10;
  logic        mem_signed = 1'b0;
  logic [31:0] mem_load_data;
  logic        mem_ready;
  logic        ext_valid;
  logic        ext_write;
  logic [31:0] ext_address;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_strobe;
  logic [31:0] ext_rdata = '0;
  logic        ext_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_fetch_data = '0;
  logic [31:0] exp_load_data = '0;
  bit          load_known = 1'b1;

  bus_arbiter #(.FAIR_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_req      (fetch_req),
    .fetch_address  (fetch_address),
    .fetch_data     (fetch_data),
    .fetch_ready    (fetch_ready),
    .mem_load       (mem_load),
    .mem_store      (mem_store),
    .mem_address    (mem_address),
    .mem_store_data (mem_store_data),
    .mem_size       (mem_size),
    .mem_signed     (mem_signed),
    .mem_load_data  (mem_load_data),
    .mem_ready      (mem_ready),
    .ext_valid      (ext_valid),
    .ext_write      (ext_write),
    .ext_address    (ext_address),
    .ext_wdata      (ext_wdata),
    .ext_strobe     (ext_strobe),
    .ext_rdata      (ext_rdata),
    .ext_ready      (ext_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an access covers n bytes starting at byte offset off.
  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_strobe(input logic [1:0] size, input logic [1:0] a);
    int n, off;
    logic [3:0] s;
    n   = size_bytes(size);
    off = (n == 4) ? 0 : (n == 2) ? (int'(a) & 2) : int'(a);
    s   = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] d);
    int n;
    logic [31:0] w;
    n = size_bytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic [31:0] a,
                                           input bit sgn, input logic [31:0] rd);
    int n, off;
    logic [63:0] v;
    n   = size_bytes(size);
    off = int'(a[1:0]);
    v   = 64'(rd >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
    if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // kind: 0 fetch, 1 load, 2 store, 3 load+store (acts as store)
  task automatic run_txn(input string name, input int kind, input logic [31:0] addr,
                         input logic [1:0] size, input bit sgn, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int lat, input bit drop);
    bit          is_f, e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    is_f   = (kind == 0);
    e_wr   = (kind >= 2);
    e_addr = {addr[31:2], 2'b00};
    e_strb = is_f ? 4'hF : exp_strobe(size, addr[1:0]);
    if (is_f) begin
      fetch_req     = 1'b1;
      fetch_address = addr;
    end else begin
      mem_load       = (kind == 1 || kind == 3);
      mem_store      = (kind >= 2);
      mem_address    = addr;
      mem_size       = size;
      mem_signed     = sgn;
      mem_store_data = sdata;
    end
    step();
    tests++;
    if (ext_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s grant_latency: ext_valid got %b want 1", name, ext_valid);
      for (int w = 0; w < 20 && ext_valid !== 1'b1; w++) step();
    end
    tests++;
    if (ext_address !== e_addr) begin
      fails++;
      $display("FAIL %s ext_address: got %h want %h", name, ext_address, e_addr);
    end
    tests++;
    if (ext_write !== e_wr) begin
      fails++;
      $display("FAIL %s ext_write: got %b want %b", name, ext_write, e_wr);
    end
    tests++;
    if (ext_strobe !== e_strb) begin
      fails++;
      $display("FAIL %s ext_strobe: got %b want %b", name, ext_strobe, e_strb);
    end
    if (e_wr) begin
      tests++;
      if (ext_wdata !== exp_wdata(size, sdata)) begin
        fails++;
        $display("FAIL %s ext_wdata: got %h want %h", name, ext_wdata, exp_wdata(size, sdata));
      end
    end
    if (drop) begin
      fetch_req   = 1'b0;
      mem_load    = 1'b0;
      mem_store   = 1'b0;
      mem_address = $urandom;
      mem_size    = 2'($urandom);
    end
    for (int l = 0; l < lat; l++) begin
      ext_rdata = $urandom;
      step();
      tests++;
      if (ext_valid !== 1'b1 || ext_address !== e_addr || ext_strobe !== e_strb ||
          fetch_ready !== 1'b0 || mem_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold_wait%0d: valid/addr/strb/fr/mr got %b/%h/%b/%b/%b want 1/%h/%b/0/0",
                 name, l, ext_valid, ext_address, ext_strobe, fetch_ready, mem_ready,
                 e_addr, e_strb);
      end
    end
    ext_ready = 1'b1;
    ext_rdata = rdata;
    step();
    ext_ready = 1'b0;
    ext_rdata = $urandom;
    if (is_f) exp_fetch_data = rdata;
    else if (kind == 1) begin
      exp_load_data = exp_load(size, addr, sgn, rdata);
      load_known    = 1'b1;
    end else load_known = 1'b0;
    tests++;
    if (fetch_ready !== is_f || mem_ready !== !is_f) begin
      fails++;
      $display("FAIL %s ready_pulse: fetch_ready/mem_ready got %b/%b want %b/%b",
               name, fetch_ready, mem_ready, is_f, !is_f);
    end
    tests++;
    if (fetch_data !== exp_fetch_data) begin
      fails++;
      $display("FAIL %s fetch_data: got %h want %h", name, fetch_data, exp_fetch_data);
    end
    if (load_known) begin
      tests++;
      if (mem_load_data !== exp_load_data) begin
        fails++;
        $display("FAIL %s mem_load_data: got %h want %h", name, mem_load_data, exp_load_data);
      end
    end
    fetch_req = 1'b0;
    mem_load  = 1'b0;
    mem_store = 1'b0;
    step();
    tests++;
    if (fetch_ready !== 1'b0 || mem_ready !== 1'b0 || ext_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s done_idle: fr/mr/valid got %b/%b/%b want 0/0/0",
               name, fetch_ready, mem_ready, ext_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++;
    if ({ext_valid, ext_write, ext_strobe, fetch_ready, mem_ready} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: valid/write/strb/fr/mr got %b/%b/%b/%b/%b want all 0",
               ext_valid, ext_write, ext_strobe, fetch_ready, mem_ready);
    end
    tests++;
    if (fetch_data !== 32'h0 || mem_load_data !== 32'h0 || ext_address !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: fetch/load/addr got %h/%h/%h want 0/0/0",
               fetch_data, mem_load_data, ext_address);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_txn("fetch_only", 0, 32'h100, 2'b10, 1'b0, 32'h0, 32'h0000_0013, 2, 1'b0);
    tests++;
    if (exp_fetch_data !== 32'h13 || fetch_data !== 32'h13) begin
      fails++;
      $display("FAIL fetch_only_value: got %h want 00000013", fetch_data);
    end
    run_txn("lb_signed", 1, 32'h203, 2'b00, 1'b1, 32'h0, 32'h8011_2233, 1, 1'b0);
    tests++;
    if (mem_load_data !== 32'hFFFF_FF80) begin
      fails++;
      $display("FAIL lb_signed_value: got %h want ffffff80", mem_load_data);
    end
    run_txn("lb_unsigned", 1, 32'h203, 2'b00, 1'b0, 32'h0, 32'h8011_2233, 0, 1'b0);
    tests++;
    if (mem_load_data !== 32'h0000_0080) begin
      fails++;
      $display("FAIL lb_unsigned_value: got %h want 00000080", mem_load_data);
    end
    run_txn("sh_store", 2, 32'h302, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0, 1, 1'b0);
    run_txn("load_and_store", 3, 32'h40C, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 0, 1'b0);
    run_txn("size11_word", 1, 32'h500, 2'b11, 1'b1, 32'h0, 32'h8765_4321, 0, 1'b0);
    run_txn("drop_midway", 1, 32'h602, 2'b01, 1'b1, 32'h0, 32'h9ABC_DEF0, 2, 1'b1);
  endtask

  task automatic test_priority();
    fetch_req     = 1'b1;
    fetch_address = 32'h800;
    mem_load      = 1'b1;
    mem_address   = 32'h200;
    mem_size      = 2'b10;
    step();
    tests++;
    if (ext_valid !== 1'b1 || ext_address !== 32'h200) begin
      fails++;
      $display("FAIL prio_data_first: valid/addr got %b/%h want 1/00000200", ext_valid, ext_address);
    end
    ext_ready = 1'b1;
    ext_rdata = 32'hCAFE_0001;
    step();
    ext_ready     = 1'b0;
    mem_load      = 1'b0;
    exp_load_data = 32'hCAFE_0001;
    load_known    = 1'b1;
    tests++;
    if (mem_ready !== 1'b1 || fetch_ready !== 1'b0 || mem_load_data !== exp_load_data) begin
      fails++;
      $display("FAIL prio_data_done: mr/fr/data got %b/%b/%h want 1/0/%h",
               mem_ready, fetch_ready, mem_load_data, exp_load_data);
    end
    step();
    tests++;
    if (ext_valid !== 1'b0) begin
      fails++;
      $display("FAIL prio_done_no_grant: ext_valid got %b want 0", ext_valid);
    end
    step();
    tests++;
    if (ext_valid !== 1'b1 || ext_address !== 32'h800 || ext_write !== 1'b0 ||
        ext_strobe !== 4'hF) begin
      fails++;
      $display("FAIL prio_fetch_next: valid/addr/wr/strb got %b/%h/%b/%b want 1/00000800/0/1111",
               ext_valid, ext_address, ext_write, ext_strobe);
    end
    ext_ready = 1'b1;
    ext_rdata = 32'h0000_0093;
    step();
    ext_ready      = 1'b0;
    fetch_req      = 1'b0;
    exp_fetch_data = 32'h0000_0093;
    tests++;
    if (fetch_ready !== 1'b1 || mem_ready !== 1'b0 || fetch_data !== exp_fetch_data ||
        mem_load_data !== exp_load_data) begin
      fails++;
      $display("FAIL prio_fetch_done: fr/mr/fdata/ldata got %b/%b/%h/%h want 1/0/%h/%h",
               fetch_ready, mem_ready, fetch_data, mem_load_data, exp_fetch_data, exp_load_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    mem_load    = 1'b1;
    mem_address = 32'h700;
    mem_size    = 2'b10;
    step();
    tests++;
    if (ext_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_setup: ext_valid got %b want 1", ext_valid);
    end
    reset    = 1'b1;
    mem_load = 1'b0;
    step();
    reset          = 1'b0;
    exp_fetch_data = 32'h0;
    exp_load_data  = 32'h0;
    load_known     = 1'b1;
    tests++;
    if (ext_valid !== 1'b0 || mem_ready !== 1'b0 || fetch_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_abandon: valid/mr/fr got %b/%b/%b want 0/0/0",
               ext_valid, mem_ready, fetch_ready);
    end
    step();
    tests++;
    if (ext_valid !== 1'b0 || mem_ready !== 1'b0 || mem_load_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_after: valid/mr/data got %b/%b/%h want 0/0/0",
               ext_valid, mem_ready, mem_load_data);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [31:0] rd;
    rd          = $urandom;
    pulses      = 0;
    mem_load    = 1'b1;
    mem_address = 32'h400;
    mem_size    = 2'b10;
    ext_ready   = 1'b1;
    ext_rdata   = rd;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (mem_ready === 1'b1) pulses++;
      tests++;
      if (ext_valid !== (k % 3 == 1) || mem_ready !== (k % 3 == 2)) begin
        fails++;
        $display("FAIL b2b_cycle%0d: valid/mem_ready got %b/%b want %b/%b",
                 k, ext_valid, mem_ready, (k % 3 == 1), (k % 3 == 2));
      end
    end
    mem_load      = 1'b0;
    ext_ready     = 1'b0;
    exp_load_data = rd;
    load_known    = 1'b1;
    tests++;
    if (pulses != 4 || mem_load_data !== rd) begin
      fails++;
      $display("FAIL b2b_throughput: pulses/data got %0d/%h want 4/%h", pulses, mem_load_data, rd);
    end
    step();
  endtask

  task automatic test_fairness();
    bit exp_f, got_f;
    fetch_req     = 1'b1;
    fetch_address = 32'h1000;
    mem_load      = 1'b1;
    mem_address   = 32'h2000;
    mem_size      = 2'b10;
    ext_ready     = 1'b1;
    ext_rdata     = 32'h5A5A_1234;
    for (int g = 0; g < 6; g++) begin
      for (int w = 0; w < 20 && ext_valid !== 1'b1; w++) step();
`ifdef ARBITER_FAIRNESS_EN
      exp_f = (g == 4);
`else
      exp_f = 1'b0;
`endif
      got_f = (ext_address === 32'h1000);
      tests++;
      if (ext_valid !== 1'b1 || got_f !== exp_f) begin
        fails++;
        $display("FAIL fair_grant%0d: valid/is_fetch got %b/%b want 1/%b", g, ext_valid, got_f, exp_f);
        break;
      end
      if (g == 5) begin
        mem_load  = 1'b0;
        fetch_req = 1'b0;
      end
      step();
      if (g < 5) step();
    end
    mem_load  = 1'b0;
    fetch_req = 1'b0;
    ext_ready = 1'b0;
    step();
    step();
    exp_load_data = 32'h5A5A_1234;
    load_known    = 1'b1;
`ifdef ARBITER_FAIRNESS_EN
    exp_fetch_data = 32'h5A5A_1234;
`endif
    tests++;
    if (ext_valid !== 1'b0 || mem_load_data !== exp_load_data || fetch_data !== exp_fetch_data) begin
      fails++;
      $display("FAIL fair_settle: valid/ldata/fdata got %b/%h/%h want 0/%h/%h",
               ext_valid, mem_load_data, fetch_data, exp_load_data, exp_fetch_data);
    end
  endtask

  task automatic test_random();
    int kind;
    logic [1:0]  size;
    logic [31:0] a;
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      size = 2'($urandom_range(0, 3));
      a    = $urandom;
      if (kind == 0 || size[1]) a[1:0] = 2'b00;
      else if (size == 2'b01) a[0] = 1'b0;
      run_txn($sformatf("rand%0d", t), kind, a, size, 1'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    test_fairness();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
